// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b1000;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_BEQ = 4'b1111;
  localparam logic [3:0] OP_BLT = 4'b1101;
  localparam logic [3:0] OP_BGT = 4'b1110;
  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SHL = 4'b0101;
  localparam logic [3:0] OP_SHR = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b1001;
  localparam logic [3:0] OP_DIV = 4'b1010;
  localparam logic [3:0] OP_REM = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } alu_state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the operand-read stage and the ALU.
interface alu_seq_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_code;
  logic [WIDTH-1:0] reg_data1;
  logic [WIDTH-1:0] reg_data2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] accum;
  logic             pc_branch;
  logic             flag_zero;
  logic             flag_carry;
  logic             flag_ovf;
  logic             flag_dz;

  modport master (
    output in_valid, alu_code, reg_data1, reg_data2, out_ready,
    input  in_ready, out_valid, accum, pc_branch, flag_zero, flag_carry, flag_ovf, flag_dz
  );

  modport slave (
    input  in_valid, alu_code, reg_data1, reg_data2, out_ready,
    output in_ready, out_valid, accum, pc_branch, flag_zero, flag_carry, flag_ovf, flag_dz
  );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative one-bit-per-cycle multiplier (shift-add, LSB first) and
// restoring divider (MSB first). hi/lo hold product high/low or remainder/quotient.
// done_o marks the final iteration cycle; hi_nx_o/lo_nx_o then carry the finished result.
module alu_muldiv #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_nx_o,
  output logic [WIDTH-1:0] lo_nx_o
);

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  logic             busy_q, busy_d;
  logic             div_q, div_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   shl_s;
  logic [WIDTH:0]   trial_s;

  // One iteration of shift-add or restoring division, plus operand load on start.
  always_comb begin
    busy_d  = busy_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    add_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    shl_s   = {hi_q, lo_q[WIDTH-1]};
    trial_s = shl_s - {1'b0, b_q};
    if (start_i) begin
      busy_d = 1'b1;
      div_d  = div_i;
      cnt_d  = {SHW{1'b0}};
      hi_d   = {WIDTH{1'b0}};
      lo_d   = a_i;
      b_d    = b_i;
    end else if (busy_q) begin
      if (div_q) begin
        if (trial_s[WIDTH]) begin
          hi_d = shl_s[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end else begin
          hi_d = trial_s[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end
      end else begin
        hi_d = add_s[WIDTH:1];
        lo_d = {add_s[0], lo_q[WIDTH-1:1]};
      end
      if (cnt_q == CNT_LAST) begin
        busy_d = 1'b0;
        cnt_d  = {SHW{1'b0}};
      end else begin
        cnt_d = cnt_q + {{(SHW-1){1'b0}}, 1'b1};
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Datapath and iteration counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= {SHW{1'b0}};
      hi_q   <= {WIDTH{1'b0}};
      lo_q   <= {WIDTH{1'b0}};
      b_q    <= {WIDTH{1'b0}};
    end else begin
      busy_q <= busy_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      b_q    <= b_d;
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = busy_q && (cnt_q == CNT_LAST);
  assign hi_nx_o = hi_d;
  assign lo_nx_o = lo_d;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops computed at accept, MUL/DIV/REM delegated
// to alu_muldiv. Result and flags are registered and held until taken.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);

  alu_state_t       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] accum_q, accum_d;
  logic             branch_q, branch_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;
  logic             is_mul_q, is_mul_d;
  logic             is_rem_q, is_rem_d;

  logic [WIDTH-1:0] a_s, b_s, sc_accum_s, md_res_s;
  logic [WIDTH:0]   sum_s;
  logic [3:0]       code_s;
  logic             accept_s, exec_op_s;
  logic             sc_branch_s, sc_zero_s, sc_carry_s, sc_ovf_s, sc_dz_s;
  logic             md_busy_s, md_done_s;
  logic [WIDTH-1:0] md_hi_s, md_lo_s;

  assign a_s       = bus.reg_data1;
  assign b_s       = bus.reg_data2;
  assign code_s    = bus.alu_code;
  assign accept_s  = bus.in_valid && in_ready_q;
  assign exec_op_s = (code_s == OP_MUL) ||
                     (((code_s == OP_DIV) || (code_s == OP_REM)) && (b_s != {WIDTH{1'b0}}));

  // Single-cycle result and flags from the live operands (used only at accept).
  always_comb begin
    sc_accum_s  = {WIDTH{1'b0}};
    sc_branch_s = 1'b0;
    sc_carry_s  = 1'b0;
    sc_ovf_s    = 1'b0;
    sc_dz_s     = 1'b0;
    sum_s       = {1'b0, a_s} + {1'b0, b_s};
    case (code_s)
      OP_ADD: begin
        sc_accum_s = sum_s[WIDTH-1:0];
        sc_carry_s = sum_s[WIDTH];
        sc_ovf_s   = (a_s[WIDTH-1] == b_s[WIDTH-1]) && (sum_s[WIDTH-1] != a_s[WIDTH-1]);
      end
      OP_SUB: begin
        sc_accum_s = a_s - b_s;
        sc_carry_s = a_s < b_s;
        sc_ovf_s   = (a_s[WIDTH-1] != b_s[WIDTH-1]) && (sc_accum_s[WIDTH-1] != a_s[WIDTH-1]);
      end
      OP_BEQ: sc_branch_s = (a_s == b_s);
      OP_BLT: sc_branch_s = (a_s < b_s);
      OP_BGT: sc_branch_s = (a_s > b_s);
      OP_AND: sc_accum_s  = a_s & b_s;
      OP_OR:  sc_accum_s  = a_s | b_s;
      OP_XOR: sc_accum_s  = a_s ^ b_s;
      OP_SHL: sc_accum_s  = a_s << b_s[SHW-1:0];
      OP_SHR: sc_accum_s  = a_s >> b_s[SHW-1:0];
      OP_DIV: begin
        sc_accum_s = {WIDTH{1'b1}};
        sc_dz_s    = 1'b1;
      end
      OP_REM: begin
        sc_accum_s = a_s;
        sc_dz_s    = 1'b1;
      end
      default: sc_accum_s = {WIDTH{1'b0}};
    endcase
    // Compares report zero=1; undefined codes report every flag as 0.
    case (code_s)
      OP_BEQ, OP_BLT, OP_BGT: sc_zero_s = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_DIV, OP_REM:
        sc_zero_s = (sc_accum_s == {WIDTH{1'b0}});
      default: sc_zero_s = 1'b0;
    endcase
  end

  assign md_res_s = is_mul_q ? md_lo_s : (is_rem_q ? md_hi_s : md_lo_s);

  // FSM and result-register next state.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    accum_d     = accum_q;
    branch_d    = branch_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    dz_d        = dz_q;
    is_mul_d    = is_mul_q;
    is_rem_d    = is_rem_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          in_ready_d = 1'b0;
          is_mul_d   = (code_s == OP_MUL);
          is_rem_d   = (code_s == OP_REM);
          if (exec_op_s) begin
            state_d = EXEC;
          end else begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            accum_d     = sc_accum_s;
            branch_d    = sc_branch_s;
            zero_d      = sc_zero_s;
            carry_d     = sc_carry_s;
            ovf_d       = sc_ovf_s;
            dz_d        = sc_dz_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        if (md_done_s) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          accum_d     = md_res_s;
          branch_d    = 1'b0;
          zero_d      = (md_res_s == {WIDTH{1'b0}});
          carry_d     = 1'b0;
          ovf_d       = is_mul_q && (md_hi_s != {WIDTH{1'b0}});
          dz_d        = 1'b0;
        end else begin
          state_d = EXEC;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, handshake and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      accum_q     <= {WIDTH{1'b0}};
      branch_q    <= 1'b0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
      is_mul_q    <= 1'b0;
      is_rem_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      accum_q     <= accum_d;
      branch_q    <= branch_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      dz_q        <= dz_d;
      is_mul_q    <= is_mul_d;
      is_rem_q    <= is_rem_d;
    end
  end

  alu_muldiv #(.WIDTH(WIDTH), .SHW(SHW)) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept_s && exec_op_s),
    .div_i   (code_s != OP_MUL),
    .a_i     (a_s),
    .b_i     (b_s),
    .busy_o  (md_busy_s),
    .done_o  (md_done_s),
    .hi_nx_o (md_hi_s),
    .lo_nx_o (md_lo_s)
  );

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.accum      = accum_q;
  assign bus.pc_branch  = branch_q;
  assign bus.flag_zero  = zero_q;
  assign bus.flag_carry = carry_q;
  assign bus.flag_ovf   = ovf_q;
  assign bus.flag_dz    = dz_q;

  logic unused_s;
  assign unused_s = md_busy_s;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=16.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   nvec;
  int   nmis;

  alu_seq_if #(.WIDTH(16)) bus ();

  alu_seq #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait for the result, optionally stall, then take it.
  task automatic run_op(input string tag, input logic [3:0] code,
                        input logic [15:0] a, input logic [15:0] b,
                        input bit rdy_early, input int hold,
                        input logic [15:0] e_acc, input logic e_br, input logic e_z,
                        input logic e_c, input logic e_o, input logic e_dz, input int e_lat);
    int lat;
    bit busy_ok;
    bit held_ok;
    check_val({tag, ".in_ready_idle"}, bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.alu_code  = code;
    bus.reg_data1 = a;
    bus.reg_data2 = b;
    bus.out_ready = rdy_early;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.reg_data1 = ~a;
    bus.reg_data2 = b ^ 16'h5A5A;
    bus.alu_code  = code ^ 4'b0110;
    lat = 1;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 64) begin
      if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check_val({tag, ".latency"}, lat, e_lat);
    check_val({tag, ".in_ready_exec"}, {31'd0, busy_ok}, 1);
    check_val({tag, ".in_ready_done"}, bus.in_ready, 0);
    check_val({tag, ".accum"}, bus.accum, e_acc);
    check_val({tag, ".pc_branch"}, bus.pc_branch, e_br);
    check_val({tag, ".flag_zero"}, bus.flag_zero, e_z);
    check_val({tag, ".flag_carry"}, bus.flag_carry, e_c);
    check_val({tag, ".flag_ovf"}, bus.flag_ovf, e_o);
    check_val({tag, ".flag_dz"}, bus.flag_dz, e_dz);
    if (hold > 0) begin
      held_ok = 1'b1;
      bus.out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.accum !== e_acc) held_ok = 1'b0;
      end
      check_val({tag, ".held"}, {31'd0, held_ok}, 1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_val({tag, ".out_valid_drop"}, bus.out_valid, 0);
  endtask

  initial begin
    bit never_valid;
    nvec = 0;
    nmis = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.alu_code  = 4'b0000;
    bus.reg_data1 = 16'h0000;
    bus.reg_data2 = 16'h0000;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst.in_ready", bus.in_ready, 1);
    check_val("rst.out_valid", bus.out_valid, 0);
    check_val("rst.accum", bus.accum, 0);
    check_val("rst.flags", {bus.pc_branch, bus.flag_zero, bus.flag_carry, bus.flag_ovf, bus.flag_dz}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    //       tag      code    A         B         early hold acc      br    z     c     o     dz    lat
    run_op("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    run_op("sub_brw", OP_SUB, 16'd3,    16'd5,    1'b0, 0, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    run_op("add_wrap",OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    run_op("sub_ovf", OP_SUB, 16'h8000, 16'h0001, 1'b0, 0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    run_op("blt",     OP_BLT, 16'd2,    16'd7,    1'b0, 0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    run_op("bgt",     OP_BGT, 16'd2,    16'd7,    1'b0, 0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    run_op("beq",     OP_BEQ, 16'd9,    16'd9,    1'b0, 0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    run_op("mul300",  OP_MUL, 16'd300,  16'd300,  1'b1, 0, 16'h5F90, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 17);
    run_op("mul3x5",  OP_MUL, 16'd3,    16'd5,    1'b0, 0, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17);
    run_op("div",     OP_DIV, 16'd1000, 16'd7,    1'b0, 0, 16'd142,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17);
    run_op("rem",     OP_REM, 16'd1000, 16'd7,    1'b0, 0, 16'd6,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17);
    run_op("div0",    OP_DIV, 16'd5,    16'd0,    1'b0, 0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    run_op("rem0",    OP_REM, 16'd5,    16'd0,    1'b0, 0, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    run_op("xor_hold",OP_XOR, 16'hF0F0, 16'hFFFF, 1'b0, 5, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    run_op("and",     OP_AND, 16'hF0F0, 16'h0FF0, 1'b0, 0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    run_op("or",      OP_OR,  16'hF000, 16'h000F, 1'b0, 0, 16'hF00F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    run_op("shl17",   OP_SHL, 16'd1,    16'd17,   1'b0, 0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    run_op("shr15",   OP_SHR, 16'h8000, 16'd15,   1'b0, 0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    run_op("badop",   4'b0000,16'h1234, 16'h1234, 1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);

    // Reset in the middle of a division.
    bus.in_valid  = 1'b1;
    bus.alu_code  = OP_DIV;
    bus.reg_data1 = 16'd1000;
    bus.reg_data2 = 16'd7;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check_val("rstdiv.in_ready_exec", bus.in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("rstdiv.in_ready", bus.in_ready, 1);
    never_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (bus.out_valid !== 1'b0) never_valid = 1'b0;
      @(posedge clk); #1;
    end
    check_val("rstdiv.no_out_valid", {31'd0, never_valid}, 1);
    run_op("post_rst_add", OP_ADD, 16'd1, 16'd1, 1'b0, 0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
